// File: rtl/tac_pkg.sv
// Shared definitions for the time-accumulating pulse encoder and the neuron-side blocks.
//   - TAC_DATA_W_DEF : default magnitude width
//   - tac_win()      : accumulation window length for a given magnitude width
//   - tac_state_e    : encoder control states
//   - TAC_THERMO / TAC_SPREAD : coding mode selectors
package tac_pkg;

    localparam int TAC_DATA_W_DEF = 8;

    // Coding modes
    localparam int TAC_THERMO = 0;
    localparam int TAC_SPREAD = 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tac_state_e;

    // Window length: one cycle per representable magnitude step, 2^w - 1
    function automatic int unsigned tac_win(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/tac_rate_acc.sv
// Modulo-WIN rate accumulator used for evenly spread pulse coding.
// Each step adds N; whenever the sum reaches WIN a pulse is emitted and WIN is
// subtracted. Over WIN steps this yields exactly N pulses and returns to zero.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   i_clear    : start of a new window; step is taken from an accumulator of 0
//   i_enable   : take one step from the current accumulator value
//   i_n        : magnitude N applied to this step
//   o_pulse    : combinational pulse decision for this step (caller registers it)
module tac_rate_acc
    import tac_pkg::*;
#(
    parameter int DATA_W = TAC_DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_enable,
    input  logic [DATA_W-1:0] i_n,
    output logic              o_pulse
);

    localparam logic [DATA_W:0]   WIN_X = (DATA_W+1)'(tac_win(DATA_W));
    localparam logic [DATA_W-1:0] WIN_D = DATA_W'(tac_win(DATA_W));

    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] w_base;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_acc_nxt;

    // Step arithmetic: sum, pulse decision and wrapped next accumulator value
    always_comb begin
        w_base    = r_acc;
        w_sum     = {1'b0, r_acc} + {1'b0, i_n};
        o_pulse   = 1'b0;
        w_acc_nxt = r_acc;
        if (i_clear) begin
            w_base = {DATA_W{1'b0}};
        end else begin
            w_base = r_acc;
        end
        w_sum   = {1'b0, w_base} + {1'b0, i_n};
        o_pulse = (w_sum >= WIN_X);
        // The wrapped result is always below WIN, so DATA_W-bit modular math is exact
        if (o_pulse) begin
            w_acc_nxt = w_base + i_n - WIN_D;
        end else begin
            w_acc_nxt = w_base + i_n;
        end
    end

    // Accumulator register, advanced only on a window start or an in-window step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= {DATA_W{1'b0}};
        end else if (i_clear || i_enable) begin
            r_acc <= w_acc_nxt;
        end else begin
            r_acc <= r_acc;
        end
    end

endmodule

// File: rtl/tac_pulse_encoder.sv
// Converts a signed-magnitude activation word into a pulse train lasting one
// accumulation window of WIN = 2^DATA_W - 1 cycles, for a time-accumulating neuron.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   din         : magnitude N (0..WIN), captured on handshake
//   din_sign    : sign (1 = negative), captured on handshake
//   din_valid   : din/din_sign valid
//   din_ready   : word accepted this cycle when valid (combinational)
//   tac_out     : pulse stream (N pulses per window)
//   sign_out    : captured sign for the whole window, 0 when idle
//   frame_start : window cycle 0
//   frame_done  : window cycle WIN-1
//   busy        : window in progress
// Parameters: DATA_W magnitude width; SPREAD selects thermometer (0) or rate-spread (1).
module tac_pulse_encoder
    import tac_pkg::*;
#(
    parameter int DATA_W = TAC_DATA_W_DEF,
    parameter int SPREAD = TAC_THERMO
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_sign,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              tac_out,
    output logic              sign_out,
    output logic              frame_start,
    output logic              frame_done,
    output logic              busy
);

    localparam logic [DATA_W-1:0] LAST_IDX = DATA_W'(tac_win(DATA_W) - 32'd1);
    localparam logic [DATA_W-1:0] IDX_ONE  = {{(DATA_W-1){1'b0}}, 1'b1};

    tac_state_e        r_state;
    tac_state_e        w_state_nxt;
    logic [DATA_W-1:0] r_idx;
    logic [DATA_W-1:0] w_idx_nxt;
    logic [DATA_W-1:0] r_n;
    logic [DATA_W-1:0] w_n_nxt;
    logic              r_sign;
    logic              w_sign_nxt;

    logic              r_tac;
    logic              r_sign_out;
    logic              r_frame_start;
    logic              r_frame_done;
    logic              r_busy;

    logic              w_last;
    logic              w_accept;
    logic              w_run_nxt;
    logic              w_mode_pulse;

    // Last window cycle is the only point inside RUN where a new word may enter
    assign w_last    = (r_state == RUN) && (r_idx == LAST_IDX);
    assign din_ready = (r_state == IDLE) || w_last;
    assign w_accept  = din_valid && din_ready;

    // Next-state and next-index logic; a handshake always restarts the window at 0
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_n_nxt     = r_n;
        w_sign_nxt  = r_sign;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = RUN;
                    w_idx_nxt   = {DATA_W{1'b0}};
                    w_n_nxt     = din;
                    w_sign_nxt  = din_sign;
                end else begin
                    w_idx_nxt   = {DATA_W{1'b0}};
                end
            end
            RUN: begin
                if (w_accept) begin
                    w_state_nxt = RUN;
                    w_idx_nxt   = {DATA_W{1'b0}};
                    w_n_nxt     = din;
                    w_sign_nxt  = din_sign;
                end else if (w_last) begin
                    w_state_nxt = IDLE;
                    w_idx_nxt   = {DATA_W{1'b0}};
                end else begin
                    w_idx_nxt   = r_idx + IDX_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = {DATA_W{1'b0}};
            end
        endcase
    end

    assign w_run_nxt = (w_state_nxt == RUN);

    // Pulse decision for the window cycle about to be presented
    generate
        if (SPREAD == TAC_SPREAD) begin : g_spread
            logic w_acc_enable;
            assign w_acc_enable = (r_state == RUN) && !w_last;
            tac_rate_acc #(
                .DATA_W (DATA_W)
            ) u_rate_acc (
                .clk      (clk),
                .rst      (rst),
                .i_clear  (w_accept),
                .i_enable (w_acc_enable),
                .i_n      (w_n_nxt),
                .o_pulse  (w_mode_pulse)
            );
        end else begin : g_thermo
            assign w_mode_pulse = (w_idx_nxt < w_n_nxt);
        end
    endgenerate

    // Control state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= {DATA_W{1'b0}};
            r_n     <= {DATA_W{1'b0}};
            r_sign  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_n     <= w_n_nxt;
            r_sign  <= w_sign_nxt;
        end
    end

    // Registered outputs, computed from the next window position
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tac         <= 1'b0;
            r_sign_out    <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_tac         <= w_run_nxt && w_mode_pulse;
            r_sign_out    <= w_run_nxt && w_sign_nxt;
            r_frame_start <= w_accept;
            r_frame_done  <= w_run_nxt && (w_idx_nxt == LAST_IDX);
            r_busy        <= w_run_nxt;
        end
    end

    assign tac_out     = r_tac;
    assign sign_out    = r_sign_out;
    assign frame_start = r_frame_start;
    assign frame_done  = r_frame_done;
    assign busy        = r_busy;

endmodule

// File: tb/tb_tac_pulse_encoder.sv
// Randomized self-checking bench for tac_pulse_encoder. Two instances share the
// input stream: one thermometer-coded, one rate-spread. A window-level reference
// model predicts every output cycle from the coding rules.
module tb_tac_pulse_encoder;

    localparam int WIN = 255;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       din_sign;
    logic       din_valid;

    logic t_ready, t_tac, t_sign, t_fs, t_fd, t_busy;
    logic s_ready, s_tac, s_sign, s_fs, s_fd, s_busy;

    int n_checks = 0;
    int n_pass   = 0;

    tac_pulse_encoder #(.DATA_W(8), .SPREAD(0)) u_thermo (
        .clk(clk), .rst(rst), .din(din), .din_sign(din_sign), .din_valid(din_valid),
        .din_ready(t_ready), .tac_out(t_tac), .sign_out(t_sign),
        .frame_start(t_fs), .frame_done(t_fd), .busy(t_busy)
    );

    tac_pulse_encoder #(.DATA_W(8), .SPREAD(1)) u_spread (
        .clk(clk), .rst(rst), .din(din), .din_sign(din_sign), .din_valid(din_valid),
        .din_ready(s_ready), .tac_out(s_tac), .sign_out(s_sign),
        .frame_start(s_fs), .frame_done(s_fd), .busy(s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: window position, captured word, back-to-back marker
    bit m_busy;
    int m_idx;
    int m_n;
    bit m_sign;
    bit m_b2b;

    // Model advance on each clock edge, aborts on reset
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_idx  <= 0;
            m_n    <= 0;
            m_sign <= 1'b0;
            m_b2b  <= 1'b0;
        end else if (din_valid && (!m_busy || m_idx == WIN - 1)) begin
            m_b2b  <= m_busy;
            m_busy <= 1'b1;
            m_idx  <= 0;
            m_n    <= int'(din);
            m_sign <= din_sign;
        end else if (m_busy && m_idx == WIN - 1) begin
            m_busy <= 1'b0;
            m_idx  <= 0;
        end else if (m_busy) begin
            m_idx  <= m_idx + 1;
        end
    end

    function automatic bit exp_thermo(input int i, input int n);
        return i < n;
    endfunction

    // Evenly spread: a pulse whenever floor(i*N/WIN) steps up
    function automatic bit exp_spread(input int i, input int n);
        return ((i + 1) * n / WIN) > (i * n / WIN);
    endfunction

    int cnt_t, cnt_s, cyc, last_fs;

    // Per-cycle output comparison on the falling edge
    always @(negedge clk) begin
        logic [4:0] e_t, e_s;
        bit ready_e;
        cyc++;
        ready_e = !m_busy || (m_idx == WIN - 1);
        e_t = {m_busy, m_busy && m_idx == 0, m_busy && m_idx == WIN - 1,
               m_busy && m_sign, m_busy && exp_thermo(m_idx, m_n)};
        e_s = {m_busy, m_busy && m_idx == 0, m_busy && m_idx == WIN - 1,
               m_busy && m_sign, m_busy && exp_spread(m_idx, m_n)};
        check_eq("thermo_ready", {31'd0, t_ready}, {31'd0, ready_e});
        check_eq("spread_ready", {31'd0, s_ready}, {31'd0, ready_e});
        check_eq("thermo_outs", {27'd0, t_busy, t_fs, t_fd, t_sign, t_tac}, {27'd0, e_t});
        check_eq("spread_outs", {27'd0, s_busy, s_fs, s_fd, s_sign, s_tac}, {27'd0, e_s});
        if (m_busy) begin
            if (m_idx == 0) begin
                cnt_t = 0;
                cnt_s = 0;
                if (m_b2b) check_eq("b2b_period", cyc - last_fs, WIN);
                last_fs = cyc;
            end
            cnt_t += int'(t_tac);
            cnt_s += int'(s_tac);
            if (m_idx == WIN - 1) begin
                check_eq("thermo_count", cnt_t, m_n);
                check_eq("spread_count", cnt_s, m_n);
            end
        end
    end

    // Present a word from a falling edge until it is accepted; optionally scramble
    // din while the encoder is not ready, and optionally keep valid high afterwards
    task automatic send(input logic [7:0] n, input logic s, input bit hold, input bit scramble);
        int waited;
        waited = 0;
        din_valid = 1'b1;
        din = n;
        din_sign = s;
        while (!t_ready && waited < 600) begin
            if (scramble) begin
                din      = 8'($urandom);
                din_sign = 1'($urandom);
            end
            @(negedge clk);
            waited++;
        end
        if (waited >= 600) check_eq("send_timeout", 32'd1, 32'd0);
        din = n;
        din_sign = s;
        @(negedge clk);
        if (!hold) din_valid = 1'b0;
    endtask

    initial begin
        int guard;
        logic [7:0] rn;
        cyc = 0; last_fs = 0; cnt_t = 0; cnt_s = 0;
        rst = 1'b1;
        din = 8'd0;
        din_sign = 1'b0;
        din_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("reset_outs", {22'd0, t_tac, t_sign, t_fs, t_fd, t_busy,
                                s_tac, s_sign, s_fs, s_fd, s_busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed windows: basic, spread patterns, zero and full scale
        send(8'd3,   1'b1, 1'b0, 1'b0);
        send(8'd85,  1'b0, 1'b0, 1'b0);
        send(8'd1,   1'b1, 1'b0, 1'b0);
        send(8'd255, 1'b0, 1'b0, 1'b0);
        send(8'd0,   1'b1, 1'b0, 1'b0);
        // Back-to-back with valid held, second word under backpressure scrambling
        send(8'd10,  1'b0, 1'b1, 1'b0);
        send(8'd20,  1'b1, 1'b0, 1'b1);

        // Reset in the middle of a window
        send(8'd50, 1'b1, 1'b0, 1'b0);
        guard = 0;
        while (m_idx != 100 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check_eq("reach_idx100", guard < 400, 32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_outs", {22'd0, t_tac, t_sign, t_fs, t_fd, t_busy,
                                    s_tac, s_sign, s_fs, s_fd, s_busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("ready_after_rst", {31'd0, t_ready}, 32'd1);
        send(8'd1, 1'b0, 1'b0, 1'b0);

        // Randomized words, gaps, holds and backpressure
        for (int k = 0; k < 10; k++) begin
            case ($urandom_range(0, 5))
                0:       rn = 8'd0;
                1:       rn = 8'd1;
                2:       rn = 8'd255;
                default: rn = 8'($urandom);
            endcase
            send(rn, 1'($urandom), 1'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        din_valid = 1'b0;

        guard = 0;
        while ((m_busy || t_busy || s_busy) && guard < 600) begin
            @(negedge clk);
            guard++;
        end
        check_eq("final_idle", guard < 600, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
